// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    IDROP = 2'd3
  } arb_state_e;

  localparam int unsigned STREAK_W = 4;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                   input logic [STREAK_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle around mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    imem_req;
  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic [DATA_WIDTH-1:0]   imem_rdata;
  logic                    imem_ready;

  logic                    dmem_req;
  logic                    dmem_we;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH/8-1:0] dmem_wstrb;
  logic [DATA_WIDTH-1:0]   dmem_rdata;
  logic                    dmem_ready;

  logic                    flush;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ack;

  // Arbiter side.
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  flush, mem_rdata, mem_ack,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requester/memory side.
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output flush, mem_rdata, mem_ack,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_arb_streak_ctr.sv
// Counts consecutive data grants taken while a fetch is waiting; saturates at the limit.
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DMEM_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                grant_d,
  input  logic                grant_i,
  input  logic                imem_waiting,
  output logic [STREAK_W-1:0] count,
  output logic                limit
);

  localparam logic [STREAK_W-1:0] MAX_CNT = STREAK_W'(MAX_DMEM_STREAK);

  logic [STREAK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (grant_d) begin
      count_d = imem_waiting ? sat_inc(count_q, MAX_CNT) : '0;
    end else if (grant_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign limit = (count_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters; data wins unless fetch has starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DMEM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  arb_state_e              state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;

  logic                    imem_req_eff;
  logic                    dmem_wins;
  logic                    grant_d, grant_i;
  logic                    imem_ready, dmem_ready;
  logic [STREAK_W-1:0]     streak_cnt;
  logic                    streak_limit;
  logic                    streak_unused;

  assign imem_req_eff = bus.imem_req & ~bus.flush;
  assign dmem_wins    = bus.dmem_req & (~imem_req_eff | ~streak_limit);

  mem_arb_streak_ctr #(
    .MAX_DMEM_STREAK (MAX_DMEM_STREAK)
  ) u_streak (
    .clk          (clk),
    .rst          (rst),
    .grant_d      (grant_d),
    .grant_i      (grant_i),
    .imem_waiting (imem_req_eff),
    .count        (streak_cnt),
    .limit        (streak_limit)
  );

  // The raw count is only of interest when probing the hierarchy.
  assign streak_unused = ^streak_cnt;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (dmem_wins) begin
          grant_d = 1'b1;
          state_d = DBUSY;
          we_d    = bus.dmem_we;
          addr_d  = bus.dmem_addr;
          wdata_d = bus.dmem_wdata;
          wstrb_d = bus.dmem_wstrb;
        end else if (imem_req_eff) begin
          grant_i = 1'b1;
          state_d = IBUSY;
          we_d    = 1'b0;
          addr_d  = bus.imem_addr;
          wdata_d = '0;
          wstrb_d = '0;
        end
      end
      DBUSY: begin
        if (bus.mem_ack) begin
          dmem_ready = 1'b1;
          state_d    = IDLE;
        end
      end
      IBUSY: begin
        // A flush keeps the memory transaction alive but suppresses the fetch completion.
        if (bus.mem_ack) begin
          imem_ready = ~bus.flush;
          state_d    = IDLE;
        end else if (bus.flush) begin
          state_d = IDROP;
        end
      end
      IDROP: begin
        if (bus.mem_ack) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign bus.mem_req    = (state_q != IDLE);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.imem_ready = imem_ready;
  assign bus.dmem_ready = dmem_ready;
  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_DMEM_STREAK (MAXS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.imem_req   = 1'b0;
    bus.imem_addr  = '0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_wstrb = '0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Leaves the caller just after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== '0) begin bad++;
      $display("FAIL reset_fields: got we=%b addr=%h wdata=%h wstrb=%h want all 0", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); end
    total++; if ({bus.imem_ready, bus.dmem_ready} !== 2'b00) begin bad++;
      $display("FAIL reset_ready: got %b%b want 00", bus.imem_ready, bus.dmem_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_we = 1'b0; bus.dmem_addr = 32'h100;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL load_idle_req: got %b want 0", bus.mem_req); end
    step();
    for (int b = 1; b <= 3; b++) begin
      if (b == 3) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; end
      @(negedge clk);
      total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h100}) begin bad++;
        $display("FAIL load_busy%0d_req: got req=%b we=%b addr=%h want 1 0 00000100", b, bus.mem_req, bus.mem_we, bus.mem_addr); end
      total++; if (bus.dmem_ready !== (b == 3)) begin bad++;
        $display("FAIL load_busy%0d_dready: got %b want %b", b, bus.dmem_ready, (b == 3)); end
      total++; if (bus.imem_ready !== 1'b0) begin bad++; $display("FAIL load_busy%0d_iready: got %b want 0", b, bus.imem_ready); end
      if (b == 3) begin
        total++; if (bus.dmem_rdata !== 32'hDEADBEEF) begin bad++;
          $display("FAIL load_rdata: got %h want deadbeef", bus.dmem_rdata); end
      end
      step();
    end
    bus.dmem_req = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.dmem_ready, bus.imem_ready} !== 3'b000) begin bad++;
      $display("FAIL load_after: got req=%b dr=%b ir=%b want 000", bus.mem_req, bus.dmem_ready, bus.imem_ready); end
    step();
  endtask

  task automatic test_contention();
    int k = 0;
    logic exp_i;
    do_reset();
    bus.imem_req = 1'b1; bus.imem_addr = 32'h40;
    bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 32'h200;
    bus.dmem_wdata = 32'hA5A5A5A5; bus.dmem_wstrb = 4'hF;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11110000;
    for (int c = 0; c < 40 && k < 10; c++) begin
      @(negedge clk);
      if (bus.imem_ready === 1'b1 || bus.dmem_ready === 1'b1) begin
        exp_i = ((k % (MAXS + 1)) == MAXS);
        total++; if ({bus.imem_ready, bus.dmem_ready} !== {exp_i, ~exp_i}) begin bad++;
          $display("FAIL contention_grant%0d: got ir=%b dr=%b want ir=%b dr=%b", k, bus.imem_ready, bus.dmem_ready, exp_i, ~exp_i); end
        k++;
      end
      step();
    end
    total++; if (k != 10) begin bad++; $display("FAIL contention_count: got %0d want 10", k); end
    idle_inputs();
  endtask

  task automatic test_flush_inflight();
    do_reset();
    bus.imem_req = 1'b1; bus.imem_addr = 32'h40;
    step();
    bus.flush = 1'b1; bus.imem_req = 1'b0;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.mem_addr, bus.imem_ready} !== {1'b1, 32'h40, 1'b0}) begin bad++;
      $display("FAIL flush_fly_c0: got req=%b addr=%h ir=%b want 1 00000040 0", bus.mem_req, bus.mem_addr, bus.imem_ready); end
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.mem_addr, bus.imem_ready} !== {1'b1, 32'h40, 1'b0}) begin bad++;
      $display("FAIL flush_fly_c1: got req=%b addr=%h ir=%b want 1 00000040 0", bus.mem_req, bus.mem_addr, bus.imem_ready); end
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.imem_ready, bus.dmem_ready} !== 3'b100) begin bad++;
      $display("FAIL flush_fly_ack: got req=%b ir=%b dr=%b want 100", bus.mem_req, bus.imem_ready, bus.dmem_ready); end
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL flush_fly_idle: got %b want 0", bus.mem_req); end
    step();
  endtask

  task automatic test_flush_with_ack();
    do_reset();
    bus.imem_req = 1'b1; bus.imem_addr = 32'h80;
    step();
    bus.flush = 1'b1; bus.mem_ack = 1'b1; bus.imem_req = 1'b0;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.imem_ready} !== 2'b10) begin bad++;
      $display("FAIL flush_ack: got req=%b ir=%b want 10", bus.mem_req, bus.imem_ready); end
    step();
    bus.flush = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL flush_ack_idle: got %b want 0", bus.mem_req); end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_addr = 32'h300;
    bus.dmem_wdata = 32'h12345678; bus.dmem_wstrb = 4'hF;
    step();
    @(negedge clk);
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_wstrb} !== {1'b1, 1'b1, 4'hF}) begin bad++;
      $display("FAIL areset_busy: got req=%b we=%b wstrb=%h want 1 1 f", bus.mem_req, bus.mem_we, bus.mem_wstrb); end
    #2 rst = 1'b1; bus.mem_ack = 1'b1;
    #1;
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== '0) begin bad++;
      $display("FAIL areset_fields: got req=%b we=%b addr=%h wdata=%h wstrb=%h want all 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); end
    total++; if (bus.dmem_ready !== 1'b0) begin bad++; $display("FAIL areset_dready: got %b want 0", bus.dmem_ready); end
    #1 rst = 1'b0; idle_inputs();
    bus.imem_req = 1'b1; bus.imem_addr = 32'h44;
    step();
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADC0DE;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h44}) begin bad++;
      $display("FAIL areset_refetch: got req=%b we=%b addr=%h want 1 0 00000044", bus.mem_req, bus.mem_we, bus.mem_addr); end
    total++; if ({bus.imem_ready, bus.imem_rdata} !== {1'b1, 32'h0BADC0DE}) begin bad++;
      $display("FAIL areset_iready: got ir=%b rdata=%h want 1 0badc0de", bus.imem_ready, bus.imem_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_flush_idle();
    do_reset();
    bus.imem_req = 1'b1; bus.imem_addr = 32'h60; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL flush_idle_nogrant: got %b want 0", bus.mem_req); end
    step();
    @(negedge clk);
    total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h60}) begin bad++;
      $display("FAIL flush_idle_grant: got req=%b addr=%h want 1 00000060", bus.mem_req, bus.mem_addr); end
    step();
    idle_inputs();
  endtask

  task automatic test_random(input int n);
    logic i_act = 1'b0, d_act = 1'b0;
    logic prev_i = 1'b0, prev_d = 1'b0, prev_f = 1'b0;
    // Transaction-level model: one outstanding memory transaction or none.
    logic m_busy = 1'b0, m_fetch = 1'b0, m_drop = 1'b0;
    logic m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW/8-1:0] m_wstrb = '0;
    int m_streak = 0;
    logic exp_i, exp_d, ieff;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (d_act && prev_d) d_act = 1'b0;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1;
        bus.dmem_we    = 1'($urandom_range(0, 1));
        bus.dmem_addr  = $urandom;
        bus.dmem_wdata = $urandom;
        bus.dmem_wstrb = 4'($urandom_range(0, 15));
      end
      bus.dmem_req = d_act;
      if (i_act && (prev_i || prev_f)) i_act = 1'b0;
      if (!i_act && $urandom_range(0, 1) == 0) begin
        i_act = 1'b1;
        bus.imem_addr = $urandom & 32'h0000_FFFC;
      end
      bus.imem_req  = i_act;
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.mem_ack   = ($urandom_range(0, 2) != 0);
      bus.mem_rdata = $urandom;
      @(negedge clk);
      exp_d = m_busy && !m_fetch && bus.mem_ack;
      exp_i = m_busy && m_fetch && !m_drop && bus.mem_ack && !bus.flush;
      total++; if (bus.mem_req !== m_busy) begin bad++;
        $display("FAIL rand_req c%0d: got %b want %b", c, bus.mem_req, m_busy); end
      total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {m_we, m_addr, m_wdata, m_wstrb}) begin bad++;
        $display("FAIL rand_fields c%0d: got %b %h %h %h want %b %h %h %h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, m_we, m_addr, m_wdata, m_wstrb); end
      total++; if ({bus.imem_ready, bus.dmem_ready} !== {exp_i, exp_d}) begin bad++;
        $display("FAIL rand_ready c%0d: got ir=%b dr=%b want ir=%b dr=%b", c, bus.imem_ready, bus.dmem_ready, exp_i, exp_d); end
      if (exp_i) begin
        total++; if (bus.imem_rdata !== bus.mem_rdata) begin bad++;
          $display("FAIL rand_irdata c%0d: got %h want %h", c, bus.imem_rdata, bus.mem_rdata); end
      end
      if (exp_d) begin
        total++; if (bus.dmem_rdata !== bus.mem_rdata) begin bad++;
          $display("FAIL rand_drdata c%0d: got %h want %h", c, bus.dmem_rdata, bus.mem_rdata); end
      end
      prev_i = bus.imem_ready;
      prev_d = bus.dmem_ready;
      prev_f = bus.flush;
      if (m_busy) begin
        if (bus.mem_ack) m_busy = 1'b0;
        else if (m_fetch && bus.flush) m_drop = 1'b1;
      end else begin
        ieff = bus.imem_req && !bus.flush;
        if (bus.dmem_req && (!ieff || m_streak < MAXS)) begin
          m_busy = 1'b1; m_fetch = 1'b0; m_drop = 1'b0;
          m_we = bus.dmem_we; m_addr = bus.dmem_addr; m_wdata = bus.dmem_wdata; m_wstrb = bus.dmem_wstrb;
          m_streak = ieff ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (ieff) begin
          m_busy = 1'b1; m_fetch = 1'b1; m_drop = 1'b0;
          m_we = 1'b0; m_addr = bus.imem_addr; m_wdata = '0; m_wstrb = '0;
          m_streak = 0;
        end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_contention();
    test_flush_inflight();
    test_flush_with_ack();
    test_async_reset();
    test_flush_idle();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
